// File: rtl/wave_sequencer.sv
`default_nettype none
// ============================================================================
// wave_sequencer : phase-tick divider, period-boundary waveform select, attenuated output
// Revision 1.0
// ============================================================================
module wave_sequencer #(
  parameter int DIV_W   = 8,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [2:0]         sel,
  input  logic               sel_load,
  input  logic [DIV_W-1:0]   div,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [1:0]         amp,
  input  logic               co,
  input  logic [7:0]         w_reciprocal,
  input  logic [7:0]         w_square,
  input  logic [7:0]         w_triangle,
  input  logic [7:0]         w_sine,
  input  logic [7:0]         w_full,
  input  logic [7:0]         w_half,
  output logic               cnt_en,
  output logic [7:0]         out,
  output logic [2:0]         cur_sel,
  output logic               pending,
  output logic               switch_pulse
);

  typedef enum logic [0:0] {RUN = 1'b0, PEND = 1'b1} state_t;

  localparam logic [2:0] c_last_wave = 3'd5;

  logic [DIV_W-1:0]   r_div_cnt;
  logic               r_cnt_en;
  state_t             r_state, w_state_nxt;
  logic [2:0]         r_pend_sel, w_pend_nxt;
  logic [2:0]         r_cur_sel, w_cur_nxt;
  logic               r_switch_pulse, w_pulse_nxt;
  logic [DWELL_W-1:0] r_period_cnt, w_period_nxt;
  logic [DWELL_W-1:0] w_dwell_last;
  logic               w_boundary;
  logic [7:0]         w_wave;
  logic [7:0]         r_out;

  // A shrinking div is caught by >= so the count never has to wrap around
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
      r_cnt_en  <= 1'b0;
    end else if (r_div_cnt >= div) begin
      r_div_cnt <= '0;
      r_cnt_en  <= 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
      r_cnt_en  <= 1'b0;
    end
  end

  assign w_boundary   = co & r_cnt_en;
  assign w_dwell_last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_pend_nxt   = r_pend_sel;
    w_cur_nxt    = r_cur_sel;
    w_pulse_nxt  = 1'b0;
    w_period_nxt = r_period_cnt;
    if (mode) begin
      w_state_nxt = RUN;
      if (w_boundary) begin
        // >= keeps the rotation moving if dwell is lowered below the current count
        if (r_period_cnt >= w_dwell_last) begin
          w_cur_nxt    = (r_cur_sel >= c_last_wave) ? 3'd0 : r_cur_sel + 3'd1;
          w_period_nxt = '0;
          w_pulse_nxt  = 1'b1;
        end else begin
          w_period_nxt = r_period_cnt + DWELL_W'(1);
        end
      end
    end else begin
      w_period_nxt = '0;
      unique case (r_state)
        RUN: begin
          if (sel_load) begin
            w_pend_nxt  = sel;
            w_state_nxt = PEND;
          end
        end
        PEND: begin
          if (w_boundary) begin
            w_cur_nxt   = r_pend_sel;
            w_pulse_nxt = 1'b1;
            w_state_nxt = sel_load ? PEND : RUN;
          end
          if (sel_load) w_pend_nxt = sel;
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= RUN;
      r_pend_sel     <= 3'd0;
      r_cur_sel      <= 3'd0;
      r_switch_pulse <= 1'b0;
      r_period_cnt   <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_pend_sel     <= w_pend_nxt;
      r_cur_sel      <= w_cur_nxt;
      r_switch_pulse <= w_pulse_nxt;
      r_period_cnt   <= w_period_nxt;
    end
  end

  always_comb begin
    w_wave = 8'd0;
    unique case (r_cur_sel)
      3'd0:    w_wave = w_reciprocal;
      3'd1:    w_wave = w_square;
      3'd2:    w_wave = w_triangle;
      3'd3:    w_wave = w_sine;
      3'd4:    w_wave = w_full;
      3'd5:    w_wave = w_half;
      default: w_wave = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_out <= 8'd0;
    else      r_out <= w_wave >> amp;
  end

  assign cnt_en       = r_cnt_en;
  assign out          = r_out;
  assign cur_sel      = r_cur_sel;
  assign pending      = (r_state == PEND);
  assign switch_pulse = r_switch_pulse;

endmodule
`default_nettype wire

// File: tb/tb_wave_sequencer.sv
`default_nettype none
// ============================================================================
// tb_wave_sequencer : directed stimulus, phase-counter model, commit scoreboard
// Revision 1.0
// ============================================================================
module tb_wave_sequencer;

  logic       clk, rst, mode, sel_load, co;
  logic [2:0] sel;
  logic [7:0] div;
  logic [3:0] dwell;
  logic [1:0] amp;
  logic [7:0] w_reciprocal, w_square, w_triangle, w_sine, w_full, w_half;
  logic       cnt_en, pending, switch_pulse;
  logic [7:0] out;
  logic [2:0] cur_sel;

  logic [7:0] phase;
  logic [2:0] sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic       pulse_seen = 1'b0;

  wave_sequencer #(.DIV_W(8), .DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .sel_load(sel_load),
    .div(div), .dwell(dwell), .amp(amp), .co(co),
    .w_reciprocal(w_reciprocal), .w_square(w_square), .w_triangle(w_triangle),
    .w_sine(w_sine), .w_full(w_full), .w_half(w_half),
    .cnt_en(cnt_en), .out(out), .cur_sel(cur_sel), .pending(pending),
    .switch_pulse(switch_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External 8-bit phase counter driven by cnt_en
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        phase <= 8'd0;
    else if (cnt_en) phase <= phase + 8'd1;
  end
  assign co = (phase == 8'hFF);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [2:0] exp_sel;
    @(posedge clk);
    #1;
    cyc++;
    pulse_seen = switch_pulse;
    if (switch_pulse) begin
      if (sb.size() > 0) begin
        exp_sel = sb.pop_front();
        chk("commit_sel", 32'(cur_sel), 32'(exp_sel));
      end else begin
        chk("spurious_pulse", 32'(switch_pulse), 32'd0);
      end
    end
  endtask

  task automatic wait_boundary(input string tag);
    int n = 0;
    while (!(cnt_en && co) && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_boundary_seen"}, 32'(cnt_en & co), 32'd1);
  endtask

  task automatic manual_commit(input logic [2:0] s);
    sel = s;
    sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    sb.push_back(s);
    wait_boundary("commit");
    tick();
    chk("commit_pulse", 32'(pulse_seen), 32'd1);
  endtask

  task automatic wait_switch();
    int n = 0;
    do begin
      sel = 3'b101;
      sel_load = (cyc % 53 == 0);
      tick();
      n++;
    end while (!pulse_seen && n < 600);
    sel_load = 1'b0;
    chk("auto_switch_seen", 32'(pulse_seen), 32'd1);
  endtask

  initial begin
    int first_en, en_count, last_cyc, n;
    rst = 1'b0; mode = 1'b0; sel = 3'd0; sel_load = 1'b0;
    div = 8'd3; dwell = 4'd2; amp = 2'd0;
    w_reciprocal = 8'h81; w_square = 8'hFF; w_triangle = 8'h40;
    w_sine = 8'hC3; w_full = 8'h5A; w_half = 8'h24;

    // Reset state
    repeat (3) tick();
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_cur_sel", 32'(cur_sel), 32'd0);
    chk("rst_cnt_en", 32'(cnt_en), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_pulse", 32'(switch_pulse), 32'd0);
    rst = 1'b1;
    chk("post_rst_out", 32'(out), 32'd0);
    chk("post_rst_cur_sel", 32'(cur_sel), 32'd0);

    // Divider with div=3: one enable every 4 clocks, first on the 4th edge
    first_en = 0; en_count = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (cnt_en) begin
        en_count++;
        if (first_en == 0) first_en = i;
      end
    end
    chk("div3_first_tick", 32'(first_en), 32'd4);
    chk("div3_tick_count", 32'(en_count), 32'd4);

    // Manual select of sine at phase 100
    div = 8'd0;
    n = 0;
    while (phase != 8'd100 && n < 2000) begin tick(); n++; end
    chk("reach_phase100", 32'(phase), 32'd100);
    sel = 3'b011; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    sb.push_back(3'b011);
    chk("sine_pending", 32'(pending), 32'd1);
    wait_boundary("sine");
    chk("sine_pending_at_wrap", 32'(pending), 32'd1);
    chk("sine_not_yet", 32'(cur_sel), 32'd0);
    tick();
    chk("sine_pulse", 32'(pulse_seen), 32'd1);
    chk("sine_pending_clr", 32'(pending), 32'd0);
    tick();
    chk("sine_out", 32'(out), 32'hC3);
    chk("sine_pulse_one_cycle", 32'(switch_pulse), 32'd0);

    // Two requests before the wrap: last one wins
    sel = 3'b010; sel_load = 1'b1; tick(); sel_load = 1'b0;
    repeat (5) tick();
    sel = 3'b101; sel_load = 1'b1; tick(); sel_load = 1'b0;
    sb.push_back(3'b101);
    wait_boundary("last_wins");
    tick();
    chk("last_wins_pulse", 32'(pulse_seen), 32'd1);
    tick();
    chk("half_out", 32'(out), 32'h24);

    // Request coincident with the boundary while pending
    sel = 3'b001; sel_load = 1'b1; tick(); sel_load = 1'b0;
    sb.push_back(3'b001);
    wait_boundary("coinc");
    sel = 3'b100; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    sb.push_back(3'b100);
    chk("coinc_old_pulse", 32'(pulse_seen), 32'd1);
    chk("coinc_still_pending", 32'(pending), 32'd1);
    wait_boundary("coinc_next");
    tick();
    chk("coinc_new_pulse", 32'(pulse_seen), 32'd1);
    chk("coinc_pending_clr", 32'(pending), 32'd0);

    // Request coincident with the boundary from RUN, same value as current
    wait_boundary("run_coinc");
    sel = 3'b100; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    chk("run_coinc_nopulse", 32'(pulse_seen), 32'd0);
    chk("run_coinc_pending", 32'(pending), 32'd1);
    chk("run_coinc_held", 32'(cur_sel), 32'd4);
    sb.push_back(3'b100);
    wait_boundary("same_val");
    tick();
    chk("same_val_pulse", 32'(pulse_seen), 32'd1);

    // Attenuation and mute
    manual_commit(3'b001);
    amp = 2'd2;
    tick();
    chk("square_amp2", 32'(out), 32'h3F);
    manual_commit(3'b110);
    tick();
    chk("mute_out", 32'(out), 32'd0);

    // Auto round-robin, dwell=2 then dwell=0
    mode = 1'b1; dwell = 4'd2;
    for (int k = 0; k < 6; k++) sb.push_back(3'(k));
    sb.push_back(3'd0);
    last_cyc = 0;
    for (int k = 0; k < 7; k++) begin
      wait_switch();
      if (k > 0) chk("auto_dwell2_interval", 32'(cyc - last_cyc), 32'd512);
      last_cyc = cyc;
    end
    chk("auto_no_pending", 32'(pending), 32'd0);
    dwell = 4'd0;
    for (int k = 1; k <= 3; k++) sb.push_back(3'(k));
    for (int k = 0; k < 3; k++) begin
      wait_switch();
      chk("auto_dwell0_interval", 32'(cyc - last_cyc), 32'd256);
      last_cyc = cyc;
    end

    // Back to manual: selection held
    mode = 1'b0;
    repeat (5) tick();
    chk("manual_hold_sel", 32'(cur_sel), 32'd3);
    chk("manual_no_pending", 32'(pending), 32'd0);

    // Reset while a request is pending
    sel = 3'b010; sel_load = 1'b1; tick(); sel_load = 1'b0;
    repeat (10) tick();
    chk("pend_before_rst", 32'(pending), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_pending", 32'(pending), 32'd0);
    chk("async_rst_cur_sel", 32'(cur_sel), 32'd0);
    chk("async_rst_out", 32'(out), 32'd0);
    chk("async_rst_pulse", 32'(switch_pulse), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) tick();
    chk("after_rst_pending", 32'(pending), 32'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
